branch_comparator: RTL and testbench
====================================

// Module: branch_comparator
// PURPOSE
// - Branch-condition evaluator for the 16-bit datapath.
// - Compares readData1 against R15 and asserts compOut when the branch selected by ctrl is taken.
// - compOut feeds the PC-select mux in the same cycle; a registered copy is provided for the pipeline/hazard logic.
// PARAMETERS
// - WIDTH  16  operand width in bits (R15, readData1)
// PORTS
// - clk        in   1      system clock, rising edge
// - rst_n      in   1      asynchronous active-low reset
// - ctrl       in   2      branch type: 0=none, 1=BLT, 2=BGT, 3=BEQ
// - R15        in   WIDTH  reference operand (register R15)
// - readData1  in   WIDTH  compared operand (register-file read port 1)
// - compOut    out  1      combinational branch-taken flag
// - compOut_q  out  1      compOut registered on clk
// - flags_q    out  3      registered {lt,gt,eq} of readData1 vs R15
// - taken_cnt  out  16     taken-branch counter (present only with COMP_TAKEN_CNT_EN)
// BEHAVIOUR
// - Operands are two's-complement signed; lt = readData1 < R15, gt = readData1 > R15, eq = readData1 == R15.
// - Exactly one of lt/gt/eq is high for any operand pair.
// - compOut: ctrl=0 -> 0; ctrl=1 -> lt; ctrl=2 -> gt; ctrl=3 -> eq.
// - compOut has zero latency; it is pure combinational from ctrl/R15/readData1.
// - While rst_n=0, compOut is forced to 0.
// - X/Z on ctrl must not propagate as 1; the default case drives compOut=0.
// - compOut_q and flags_q update on every rising clk edge to the current compOut and {lt,gt,eq}; latency is 1 cycle.
// - No enable or handshake; a new compare is accepted every cycle.
// - Async reset (rst_n falling, any time): compOut_q=0, flags_q=3'b000 immediately, independent of clk.
// - After rst_n deasserts, registers resume on the next rising clk edge.
// - Boundaries:
//   - 16'h8000 (most negative) < 16'h7FFF.
//   - 16'hFFFF (-1) < 16'h0000.
//   - Equal operands: BLT=0, BGT=0, BEQ=1.
// CONFIGURATION
// - COMP_TAKEN_CNT_EN defined:
//   - taken_cnt port exists.
//   - Increments by 1 on each rising clk where compOut=1.
//   - Wraps 16'hFFFF -> 16'h0000.
//   - Reset value is 0 (async, rst_n).
// - COMP_TAKEN_CNT_EN undefined: taken_cnt port and counter logic are absent; all other behaviour is identical.
// TESTING
// - BLT: ctrl=1, R15=16'h1234, readData1=16'h1233 -> compOut=1; next edge compOut_q=1, flags_q=3'b100.
// - BLT: ctrl=1, R15=16'h1233, readData1=16'h1234 -> compOut=0; with R15=readData1=16'h1234 -> compOut=0, flags_q=3'b001.
// - BGT: ctrl=2 with the same three operand pairs -> compOut=0, 1, 0.
// - BEQ: ctrl=3 with the same three operand pairs -> compOut=0, 0, 1.
// - ctrl=0, R15=readData1=16'h0000 -> compOut=0. Signed check: ctrl=1, R15=16'h0000, readData1=16'hFFFF -> compOut=1.
// - Reset: drive rst_n=0 mid-cycle while compOut_q=1 -> compOut_q=0, flags_q=0 without a clk edge.
//   With COMP_TAKEN_CNT_EN: 3 taken cycles -> taken_cnt=3; reset -> 0.

Source files
------------

// File: rtl/branch_comparator_if.sv
// Branch-compare bus: operand/control inputs and the taken flag, registered flags and optional counter.
// taken_cnt exists only when COMP_TAKEN_CNT_EN is defined.
interface branch_comparator_if #(
   parameter int WIDTH = 16
);
   logic [1:0]       ctrl;
   logic [WIDTH-1:0] R15;
   logic [WIDTH-1:0] readData1;
   logic             compOut;
   logic             compOut_q;
   logic [2:0]       flags_q;
`ifdef COMP_TAKEN_CNT_EN
   logic [15:0]      taken_cnt;

   modport master (
      output ctrl, R15, readData1,
      input  compOut, compOut_q, flags_q, taken_cnt
   );

   modport slave (
      input  ctrl, R15, readData1,
      output compOut, compOut_q, flags_q, taken_cnt
   );
`else
   modport master (
      output ctrl, R15, readData1,
      input  compOut, compOut_q, flags_q
   );

   modport slave (
      input  ctrl, R15, readData1,
      output compOut, compOut_q, flags_q
   );
`endif
endinterface

// File: rtl/branch_comparator.sv
// Signed branch-condition evaluator: readData1 vs R15, selected by ctrl, with registered copies.
// Optional taken-branch counter enabled by COMP_TAKEN_CNT_EN.
module branch_comparator #(
   parameter int WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   branch_comparator_if.slave  bus
);
   logic signed [WIDTH-1:0] op_a_s;
   logic signed [WIDTH-1:0] op_b_s;
   logic                    lt_s;
   logic                    gt_s;
   logic                    eq_s;
   logic                    sel_s;
   logic                    comp_s;
   logic                    comp_q_r;
   logic [2:0]              flags_q_r;

   assign op_a_s = bus.readData1;
   assign op_b_s = bus.R15;

   // Signed magnitude relations of readData1 against R15.
   always_comb begin
      lt_s = 1'b0;
      gt_s = 1'b0;
      eq_s = 1'b0;
      if (op_a_s < op_b_s) begin
         lt_s = 1'b1;
      end else if (op_a_s > op_b_s) begin
         gt_s = 1'b1;
      end else begin
         eq_s = 1'b1;
      end
   end

   // Branch select; unknown ctrl falls to default so it can never read as taken.
   always_comb begin
      sel_s = 1'b0;
      case (bus.ctrl)
         2'd0:    sel_s = 1'b0;
         2'd1:    sel_s = lt_s;
         2'd2:    sel_s = gt_s;
         2'd3:    sel_s = eq_s;
         default: sel_s = 1'b0;
      endcase
      if (!rst_n) begin
         comp_s = 1'b0;
      end else begin
         comp_s = sel_s;
      end
   end

   assign bus.compOut   = comp_s;
   assign bus.compOut_q = comp_q_r;
   assign bus.flags_q   = flags_q_r;

   // One-cycle registered copies for pipeline/hazard logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         comp_q_r  <= 1'b0;
         flags_q_r <= 3'b000;
      end else begin
         comp_q_r  <= comp_s;
         flags_q_r <= {lt_s, gt_s, eq_s};
      end
   end

`ifdef COMP_TAKEN_CNT_EN
   logic [15:0] taken_cnt_r;

   // Free-running taken counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_cnt_r <= 16'h0000;
      end else if (comp_s) begin
         taken_cnt_r <= taken_cnt_r + 16'h0001;
      end else begin
         taken_cnt_r <= taken_cnt_r;
      end
   end

   assign bus.taken_cnt = taken_cnt_r;
`endif
endmodule

// File: tb/tb_branch_comparator.sv
// Directed testbench for branch_comparator with hand-computed expectations.
module tb_branch_comparator;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   branch_comparator_if #(.WIDTH(16)) bus ();

   branch_comparator #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive a vector after negedge, check compOut, then the registered copies after the edge.
   task automatic vec(input string tag, input logic [1:0] c, input logic [15:0] r15,
                      input logic [15:0] rd1, input logic exp_c, input logic [2:0] exp_f);
      @(negedge clk);
      bus.ctrl      = c;
      bus.R15       = r15;
      bus.readData1 = rd1;
      #1;
      check({tag, ".compOut"}, {15'd0, bus.compOut}, {15'd0, exp_c});
      @(posedge clk);
      #1;
      check({tag, ".compOut_q"}, {15'd0, bus.compOut_q}, {15'd0, exp_c});
      check({tag, ".flags_q"}, {13'd0, bus.flags_q}, {13'd0, exp_f});
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.ctrl      = 2'd1;
      bus.R15       = 16'h1234;
      bus.readData1 = 16'h1233;
      #3;
      check("rst.compOut", {15'd0, bus.compOut}, 16'h0000);
      check("rst.compOut_q", {15'd0, bus.compOut_q}, 16'h0000);
      check("rst.flags_q", {13'd0, bus.flags_q}, 16'h0000);
`ifdef COMP_TAKEN_CNT_EN
      check("rst.taken_cnt", bus.taken_cnt, 16'h0000);
`endif
      @(negedge clk);
      bus.ctrl = 2'd0;
      rst_n    = 1'b1;

      vec("blt_lt", 2'd1, 16'h1234, 16'h1233, 1'b1, 3'b100);
      vec("blt_gt", 2'd1, 16'h1233, 16'h1234, 1'b0, 3'b010);
      vec("blt_eq", 2'd1, 16'h1234, 16'h1234, 1'b0, 3'b001);
      vec("bgt_lt", 2'd2, 16'h1234, 16'h1233, 1'b0, 3'b100);
      vec("bgt_gt", 2'd2, 16'h1233, 16'h1234, 1'b1, 3'b010);
      vec("bgt_eq", 2'd2, 16'h1234, 16'h1234, 1'b0, 3'b001);
      vec("beq_lt", 2'd3, 16'h1234, 16'h1233, 1'b0, 3'b100);
      vec("beq_gt", 2'd3, 16'h1233, 16'h1234, 1'b0, 3'b010);
      vec("beq_eq", 2'd3, 16'h1234, 16'h1234, 1'b1, 3'b001);
      vec("none_eq", 2'd0, 16'h0000, 16'h0000, 1'b0, 3'b001);
      vec("none_lt", 2'd0, 16'h0001, 16'h0000, 1'b0, 3'b100);
      vec("blt_m1", 2'd1, 16'h0000, 16'hFFFF, 1'b1, 3'b100);
      vec("blt_min", 2'd1, 16'h7FFF, 16'h8000, 1'b1, 3'b100);
      vec("bgt_max", 2'd2, 16'h8000, 16'h7FFF, 1'b1, 3'b010);
      vec("bgt_m1", 2'd2, 16'hFFFF, 16'h0000, 1'b1, 3'b010);
      vec("beq_neg", 2'd3, 16'h8000, 16'h8000, 1'b1, 3'b001);

      // ctrl of X must not read as taken
      @(negedge clk);
      bus.ctrl      = 2'bxx;
      bus.R15       = 16'h1234;
      bus.readData1 = 16'h1234;
      #1;
      check("ctrl_x.compOut", {15'd0, bus.compOut}, 16'h0000);

      // Mid-cycle async reset while compOut_q is high
      vec("pre_rst", 2'd1, 16'h1234, 16'h1233, 1'b1, 3'b100);
      #2;
      rst_n = 1'b0;
      #1;
      check("async.compOut_q", {15'd0, bus.compOut_q}, 16'h0000);
      check("async.flags_q", {13'd0, bus.flags_q}, 16'h0000);
      check("async.compOut", {15'd0, bus.compOut}, 16'h0000);
      @(negedge clk);
      bus.ctrl = 2'd0;
      rst_n    = 1'b1;
      vec("post_rst", 2'd3, 16'h0042, 16'h0042, 1'b1, 3'b001);

`ifdef COMP_TAKEN_CNT_EN
      @(negedge clk);
      bus.ctrl = 2'd0;
      rst_n    = 1'b0;
      #1;
      check("cnt.clear", bus.taken_cnt, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("cnt.idle", bus.taken_cnt, 16'h0000);
      bus.ctrl      = 2'd1;
      bus.R15       = 16'h0010;
      bus.readData1 = 16'h0001;
      repeat (3) @(negedge clk);
      bus.ctrl = 2'd0;
      check("cnt.three", bus.taken_cnt, 16'h0003);
      @(negedge clk);
      check("cnt.hold", bus.taken_cnt, 16'h0003);
      rst_n = 1'b0;
      #1;
      check("cnt.reset", bus.taken_cnt, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
`endif

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
